// File: rtl/in_skew_buffer_pkg.sv
// Shared types and sizing helpers for the systolic-array input skew buffer.
package in_skew_buffer_pkg;

    localparam int DEF_I_WIDTH = 8;
    localparam int DEF_F_WIDTH = 8;
    localparam int DEF_N       = 3;
    localparam int DEF_W       = DEF_I_WIDTH + DEF_F_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } skew_state_t;

    function automatic int rowsWidth(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int wordWidth(input int iw, input int fw);
        return iw + fw;
    endfunction

endpackage

// File: rtl/skew_row_delay.sv
// Enable-driven delay line for one array row; data, valid and last tags move together.
module skew_row_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    input  logic         in_last_i,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    output logic         out_last_o
);

    logic [W-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_last;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
            r_last  <= '0;
        end else if (en_i) begin
            r_data[0]  <= in_data_i;
            r_valid[0] <= in_valid_i;
            r_last[0]  <= in_last_i;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    assign out_data_o  = r_data[DEPTH-1];
    assign out_valid_o = r_valid[DEPTH-1];
    assign out_last_o  = r_last[DEPTH-1];

endmodule

// File: rtl/in_skew_buffer.sv
// Input skew buffer: row r of each accepted vector is delayed by r advances so data
// enters the PE array diagonally; end-of-frame drains the stagger with zero-fill.
module in_skew_buffer
    import in_skew_buffer_pkg::*;
#(
    parameter int I_WIDTH    = DEF_I_WIDTH,
    parameter int F_WIDTH    = DEF_F_WIDTH,
    parameter int N          = DEF_N,
    parameter int ROWS_WIDTH = rowsWidth(N)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                                   cfg_ld_i,
    input  logic [ROWS_WIDTH-1:0]                  active_rows_i,
    input  logic [N*wordWidth(I_WIDTH,F_WIDTH)-1:0] in_data_i,
    input  logic                                   in_valid_i,
    input  logic                                   in_last_i,
    output logic                                   in_ready_o,
    output logic [N*wordWidth(I_WIDTH,F_WIDTH)-1:0] out_data_o,
    output logic [N-1:0]                           out_valid_o,
    output logic                                   out_last_o,
    output logic                                   busy_o
);

    localparam int W = wordWidth(I_WIDTH, F_WIDTH);

    skew_state_t           r_state;
    skew_state_t           w_nextState;
    logic [ROWS_WIDTH-1:0] r_activeRows;
    logic [ROWS_WIDTH-1:0] r_drainCnt;
    logic [ROWS_WIDTH-1:0] w_cfgRows;
    logic                  r_advQ;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_lastSel;
    logic [N-1:0]          w_rowValid;
    logic [N-1:0]          w_rowLast;

    assign in_ready_o = (r_state != DRAIN);
    assign w_accept   = in_valid_i & in_ready_o;
    assign w_advance  = w_accept | (r_state == DRAIN);
    assign busy_o     = (r_state != IDLE);

    always_comb begin
        w_cfgRows = active_rows_i;
        if (active_rows_i == '0) begin
            w_cfgRows = ROWS_WIDTH'(1);
        end else if (active_rows_i > ROWS_WIDTH'(N)) begin
            w_cfgRows = ROWS_WIDTH'(N);
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, STREAM: begin
                if (w_accept) begin
                    if (!in_last_i) begin
                        w_nextState = STREAM;
                    end else if (r_activeRows > ROWS_WIDTH'(1)) begin
                        w_nextState = DRAIN;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (r_drainCnt <= ROWS_WIDTH'(1)) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The drain counter is loaded with active_rows-1 on entry so the deepest active row empties exactly.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state      <= IDLE;
            r_activeRows <= ROWS_WIDTH'(N);
            r_drainCnt   <= '0;
            r_advQ       <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_advQ  <= w_advance;
            if (r_state == IDLE && cfg_ld_i) begin
                r_activeRows <= w_cfgRows;
            end
            if (w_nextState == DRAIN && r_state != DRAIN) begin
                r_drainCnt <= r_activeRows - ROWS_WIDTH'(1);
            end else if (r_state == DRAIN) begin
                r_drainCnt <= r_drainCnt - ROWS_WIDTH'(1);
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        logic         w_rowActive;
        logic [W-1:0] w_inWord;
        logic         w_inValid;
        logic         w_inLast;

        assign w_rowActive = (ROWS_WIDTH'(r) < r_activeRows);
        assign w_inWord    = (w_rowActive && r_state != DRAIN) ? in_data_i[r*W +: W] : '0;
        assign w_inValid   = w_rowActive & w_accept;
        assign w_inLast    = w_rowActive & w_accept & in_last_i;

        skew_row_delay #(
            .DEPTH(r + 1),
            .W    (W)
        ) u_rowDelay (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .en_i       (w_advance),
            .in_data_i  (w_inWord),
            .in_valid_i (w_inValid),
            .in_last_i  (w_inLast),
            .out_data_o (out_data_o[r*W +: W]),
            .out_valid_o(w_rowValid[r]),
            .out_last_o (w_rowLast[r])
        );

        // Gating with the registered advance stops a held word from reading as valid twice.
        assign out_valid_o[r] = r_advQ & w_rowValid[r];
    end

    always_comb begin
        w_lastSel = 1'b0;
        for (int r = 0; r < N; r++) begin
            if (ROWS_WIDTH'(r) == r_activeRows - ROWS_WIDTH'(1)) begin
                w_lastSel = out_valid_o[r] & w_rowLast[r];
            end
        end
    end

    assign out_last_o = w_lastSel;

endmodule

// File: tb/tb_in_skew_buffer.sv
// Self-checking bench for in_skew_buffer: every cycle is compared against a
// beat-history reference model, plus scenario-specific counts.
module tb_in_skew_buffer;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int NW = N * W;
    localparam int RW = $clog2(N + 1);

    logic          clk_i;
    logic          rst_n_i;
    logic          cfg_ld_i;
    logic [RW-1:0] active_rows_i;
    logic [NW-1:0] in_data_i;
    logic          in_valid_i;
    logic          in_last_i;
    logic          in_ready_o;
    logic [NW-1:0] out_data_o;
    logic [N-1:0]  out_valid_o;
    logic          out_last_o;
    logic          busy_o;

    in_skew_buffer dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .cfg_ld_i     (cfg_ld_i),
        .active_rows_i(active_rows_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_last_i    (in_last_i),
        .in_ready_o   (in_ready_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit            rstN;
        bit            valid;
        bit            last;
        bit            cfg;
        logic [RW-1:0] rows;
        logic [NW-1:0] data;
    } stim_t;

    typedef struct {
        logic [NW-1:0] word;
        bit            valid;
        bit            last;
        int            act;
    } beat_t;

    stim_t stimQ[$];
    beat_t hist[$];
    int    mActive    = N;
    int    mDrainLeft = 0;
    bit    mBusy      = 0;
    bit    mAdvQ      = 0;
    int    checks     = 0;
    int    passed     = 0;

    // Reference model: each advance appends one beat; row r shows the beat from r advances ago.
    function automatic logic [NW-1:0] maskRows(input logic [NW-1:0] d, input int act);
        logic [NW-1:0] m;
        m = d;
        for (int r = act; r < N; r++) m[r*W +: W] = '0;
        return m;
    endfunction

    task automatic modelStep(input stim_t s);
        bit    acc;
        bit    adv;
        bit    wasBusy;
        beat_t b;
        if (!s.rstN) begin
            hist.delete();
            mActive = N; mDrainLeft = 0; mBusy = 0; mAdvQ = 0;
            return;
        end
        wasBusy = mBusy;
        acc = s.valid && (mDrainLeft == 0);
        adv = acc || (mDrainLeft > 0);
        if (adv) begin
            b.word  = acc ? maskRows(s.data, mActive) : '0;
            b.valid = acc;
            b.last  = acc && s.last;
            b.act   = mActive;
            hist.push_back(b);
            if (hist.size() > N) void'(hist.pop_front());
        end
        if (mDrainLeft > 0) begin
            mDrainLeft--;
            mBusy = (mDrainLeft > 0);
        end else if (acc) begin
            if (s.last) begin
                mDrainLeft = mActive - 1;
                mBusy = (mDrainLeft > 0);
            end else begin
                mBusy = 1;
            end
        end
        if (!wasBusy && s.cfg) begin
            if (s.rows == 0) mActive = 1;
            else if (int'(s.rows) > N) mActive = N;
            else mActive = int'(s.rows);
        end
        mAdvQ = adv;
    endtask

    function automatic logic [NW+5:0] expVec();
        logic [NW-1:0] d;
        logic [N-1:0]  v;
        logic [N-1:0]  lt;
        int            idx;
        d = '0; v = '0; lt = '0;
        for (int r = 0; r < N; r++) begin
            idx = hist.size() - 1 - r;
            if (idx >= 0 && r < hist[idx].act) begin
                d[r*W +: W] = hist[idx].word[r*W +: W];
                v[r]  = mAdvQ & hist[idx].valid;
                lt[r] = hist[idx].last;
            end
        end
        return {d, v, v[mActive-1] & lt[mActive-1], mDrainLeft == 0, mBusy};
    endfunction

    function automatic logic [NW+5:0] gotVec();
        return {out_data_o, out_valid_o, out_last_o, in_ready_o, busy_o};
    endfunction

    task automatic applyStimulus(input stim_t s);
        @(negedge clk_i);
        rst_n_i       = s.rstN;
        in_valid_i    = s.valid;
        in_last_i     = s.last;
        cfg_ld_i      = s.cfg;
        active_rows_i = s.rows;
        in_data_i     = s.data;
        modelStep(s);
        @(posedge clk_i);
        #1;
    endtask

    task automatic addCycle(input bit rstN, input bit valid, input bit last, input bit cfg,
                            input logic [RW-1:0] rows, input logic [NW-1:0] data);
        stim_t s;
        s.rstN = rstN; s.valid = valid; s.last = last; s.cfg = cfg; s.rows = rows; s.data = data;
        stimQ.push_back(s);
    endtask

    task automatic addReset();                 addCycle(0, 0, 0, 0, '0, '0);   endtask
    task automatic addCfg(input logic [RW-1:0] rows); addCycle(1, 0, 0, 1, rows, '0); endtask
    task automatic addBeat(input logic [NW-1:0] d, input bit last); addCycle(1, 1, last, 0, '0, d); endtask
    task automatic addIdle(input int n);
        for (int i = 0; i < n; i++) addCycle(1, 0, 0, 0, '0, '0);
    endtask

    function automatic logic [NW-1:0] patWord(input int k);
        logic [NW-1:0] d;
        for (int r = 0; r < N; r++) d[r*W +: W] = W'(16 * k + r);
        return d;
    endfunction

    function automatic logic [NW-1:0] randWord();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[NW-1:0];
    endfunction

    task automatic test_reset();
        stimQ.delete();
        addReset(); addReset();
        foreach (stimQ[i]) begin
            applyStimulus(stimQ[i]);
            checks++;
            if (gotVec() !== expVec()) $display("[TB] FAIL reset step %0d: got %h, expected %h", i, gotVec(), expVec());
            else passed++;
        end
        checks++;
        if (gotVec() !== {{NW{1'b0}}, 3'b000, 1'b0, 1'b1, 1'b0})
            $display("[TB] FAIL reset_values: got %h, expected %h", gotVec(), {{NW{1'b0}}, 3'b000, 3'b010});
        else passed++;
    endtask

    task automatic test_back_to_back();
        int readyLow = 0; int lastCnt = 0; int v0 = 0; int v2 = 0;
        logic [W-1:0] lastWord = '0;
        stimQ.delete();
        addReset(); addCfg(RW'(3));
        for (int k = 0; k < 4; k++) addBeat(patWord(k), k == 3);
        addIdle(5);
        foreach (stimQ[i]) begin
            applyStimulus(stimQ[i]);
            checks++;
            if (gotVec() !== expVec()) $display("[TB] FAIL b2b step %0d: got %h, expected %h", i, gotVec(), expVec());
            else passed++;
            if (!in_ready_o) readyLow++;
            if (out_valid_o[0]) v0++;
            if (out_valid_o[2]) v2++;
            if (out_last_o) begin lastCnt++; lastWord = out_data_o[2*W +: W]; end
        end
        checks++;
        if (readyLow != 2) $display("[TB] FAIL b2b_ready_low: got %0d, expected 2", readyLow); else passed++;
        checks++;
        if (lastCnt != 1) $display("[TB] FAIL b2b_last_count: got %0d, expected 1", lastCnt); else passed++;
        checks++;
        if (lastWord !== 16'h0032) $display("[TB] FAIL b2b_last_word: got %h, expected 0032", lastWord); else passed++;
        checks++;
        if (v0 != 4 || v2 != 4) $display("[TB] FAIL b2b_valid_counts: got %0d/%0d, expected 4/4", v0, v2); else passed++;
    endtask

    task automatic test_bubble();
        int vc[N]; int lastCnt = 0;
        for (int r = 0; r < N; r++) vc[r] = 0;
        stimQ.delete();
        addReset(); addCfg(RW'(3));
        addBeat(patWord(0), 0); addBeat(patWord(1), 0); addIdle(2);
        addBeat(patWord(2), 0); addBeat(patWord(3), 1); addIdle(5);
        foreach (stimQ[i]) begin
            applyStimulus(stimQ[i]);
            checks++;
            if (gotVec() !== expVec()) $display("[TB] FAIL bubble step %0d: got %h, expected %h", i, gotVec(), expVec());
            else passed++;
            for (int r = 0; r < N; r++) if (out_valid_o[r]) vc[r]++;
            if (out_last_o) lastCnt++;
        end
        checks++;
        if (vc[0] != 4 || vc[1] != 4 || vc[2] != 4)
            $display("[TB] FAIL bubble_valid_counts: got %0d/%0d/%0d, expected 4/4/4", vc[0], vc[1], vc[2]);
        else passed++;
        checks++;
        if (lastCnt != 1) $display("[TB] FAIL bubble_last_count: got %0d, expected 1", lastCnt); else passed++;
    endtask

    task automatic test_single_row();
        int readyLow = 0; int busyCnt = 0; int lastCnt = 0;
        logic [W-1:0] lastWord = '0;
        logic [NW-1:0] d;
        d = randWord();
        d[W-1:0] = 16'h7F00;
        stimQ.delete();
        addReset(); addCfg(RW'(1)); addBeat(d, 1); addIdle(3);
        foreach (stimQ[i]) begin
            applyStimulus(stimQ[i]);
            checks++;
            if (gotVec() !== expVec()) $display("[TB] FAIL single step %0d: got %h, expected %h", i, gotVec(), expVec());
            else passed++;
            if (!in_ready_o) readyLow++;
            if (busy_o) busyCnt++;
            if (out_last_o) begin lastCnt++; lastWord = out_data_o[W-1:0]; end
        end
        checks++;
        if (readyLow != 0 || busyCnt != 0)
            $display("[TB] FAIL single_ready_busy: got %0d/%0d, expected 0/0", readyLow, busyCnt);
        else passed++;
        checks++;
        if (lastCnt != 1 || lastWord !== 16'h7F00)
            $display("[TB] FAIL single_last: got %0d/%h, expected 1/7f00", lastCnt, lastWord);
        else passed++;
    endtask

    task automatic test_two_rows();
        int readyLow = 0; int lastCnt = 0; int row2Hits = 0;
        stimQ.delete();
        addReset(); addCfg(RW'(2));
        for (int k = 0; k < 4; k++) addBeat(randWord() | {W'(1), {(NW-W){1'b0}}}, k == 3);
        addIdle(4);
        foreach (stimQ[i]) begin
            applyStimulus(stimQ[i]);
            checks++;
            if (gotVec() !== expVec()) $display("[TB] FAIL two_rows step %0d: got %h, expected %h", i, gotVec(), expVec());
            else passed++;
            if (!in_ready_o) readyLow++;
            if (out_last_o) lastCnt++;
            if (out_valid_o[2] || out_data_o[2*W +: W] != '0) row2Hits++;
        end
        checks++;
        if (row2Hits != 0) $display("[TB] FAIL two_rows_row2: got %0d active cycles, expected 0", row2Hits); else passed++;
        checks++;
        if (readyLow != 1 || lastCnt != 1)
            $display("[TB] FAIL two_rows_drain_last: got %0d/%0d, expected 1/1", readyLow, lastCnt);
        else passed++;
    endtask

    task automatic test_cfg_ignored();
        int split; int readyA = 0; int readyB = 0; int lastB = 0;
        stimQ.delete();
        addReset(); addCfg(RW'(3));
        addBeat(randWord(), 0);
        addCycle(1, 1, 0, 1, RW'(1), randWord());
        addBeat(randWord(), 1); addIdle(4);
        split = stimQ.size();
        addCfg(RW'(0)); addBeat(randWord(), 1); addIdle(3);
        foreach (stimQ[i]) begin
            applyStimulus(stimQ[i]);
            checks++;
            if (gotVec() !== expVec()) $display("[TB] FAIL cfg step %0d: got %h, expected %h", i, gotVec(), expVec());
            else passed++;
            if (!in_ready_o) begin if (i < split) readyA++; else readyB++; end
            if (out_last_o && i >= split) lastB++;
        end
        checks++;
        if (readyA != 2) $display("[TB] FAIL cfg_stream_ignored: got %0d drain cycles, expected 2", readyA); else passed++;
        checks++;
        if (readyB != 0 || lastB != 1)
            $display("[TB] FAIL cfg_zero_as_one: got %0d/%0d, expected 0/1", readyB, lastB);
        else passed++;
    endtask

    task automatic test_reset_drain();
        int split; int lastA = 0; int lastB = 0;
        stimQ.delete();
        addReset(); addCfg(RW'(3));
        addBeat(randWord(), 0); addBeat(randWord(), 0); addBeat(randWord(), 1);
        addReset();
        split = stimQ.size();
        addIdle(1);
        for (int k = 0; k < 3; k++) addBeat(randWord(), k == 2);
        addIdle(4);
        foreach (stimQ[i]) begin
            applyStimulus(stimQ[i]);
            checks++;
            if (gotVec() !== expVec()) $display("[TB] FAIL rst_drain step %0d: got %h, expected %h", i, gotVec(), expVec());
            else passed++;
            if (i == split - 1) begin
                checks++;
                if (gotVec() !== {{NW{1'b0}}, 3'b000, 3'b010})
                    $display("[TB] FAIL rst_drain_clear: got %h, expected %h", gotVec(), {{NW{1'b0}}, 3'b000, 3'b010});
                else passed++;
            end
            if (out_last_o) begin if (i < split) lastA++; else lastB++; end
        end
        checks++;
        if (lastA != 0 || lastB != 1)
            $display("[TB] FAIL rst_drain_last: got %0d/%0d, expected 0/1", lastA, lastB);
        else passed++;
    endtask

    task automatic test_random();
        int nb;
        stimQ.delete();
        addReset();
        for (int f = 0; f < 8; f++) begin
            addCfg(RW'($urandom_range(0, 3)));
            nb = $urandom_range(1, 6);
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 99) < 30) addIdle(1);
                addBeat(randWord(), k == nb - 1);
            end
            addIdle(N + 1);
        end
        foreach (stimQ[i]) begin
            applyStimulus(stimQ[i]);
            checks++;
            if (gotVec() !== expVec()) $display("[TB] FAIL random step %0d: got %h, expected %h", i, gotVec(), expVec());
            else passed++;
        end
    endtask

    initial begin
        rst_n_i = 1'b0; cfg_ld_i = 1'b0; active_rows_i = '0;
        in_data_i = '0; in_valid_i = 1'b0; in_last_i = 1'b0;
        $display("[TB] starting in_skew_buffer bench");
        test_reset();
        test_back_to_back();
        test_bubble();
        test_single_row();
        test_two_rows();
        test_cfg_ignored();
        test_reset_drain();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/in_skew_buffer.md
Name: in_skew_buffer

Overview:
Input-side skew buffer for the systolic array; the feeding counterpart of the output de-skew shift register. Accepts one N-row input vector per beat and delays row r by r beats, so data enters the array diagonally. On end-of-frame it drains the staggered rows with zero-fill, then returns to idle. Sits between the input line buffer and the PE array's row inputs.

Parameters:
I_WIDTH, 8, integer bits of each fixed-point word
F_WIDTH, 8, fractional bits of each fixed-point word
N, 3, array rows (maximum filter size)
ROWS_WIDTH, $clog2(N+1), width of the active-row count

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_n_i  in  1  synchronous, active-low reset
cfg_ld_i  in  1  latch active_rows_i; honoured only in IDLE
active_rows_i  in  ROWS_WIDTH  number of active rows (filter size)
in_data_i  in  N*(I_WIDTH+F_WIDTH)  row r at bits [r*W +: W], W=I_WIDTH+F_WIDTH, signed
in_valid_i  in  1  input beat valid
in_last_i  in  1  marks final beat of frame
in_ready_o  out  1  buffer can accept a beat
out_data_o  out  N*W  skewed row outputs, same packing
out_valid_o  out  N  per-row valid
out_last_o  out  1  final skewed word of frame on last active row
busy_o  out  1  high in STREAM or DRAIN

Behaviour:
- Reset (rst_n_i=0 at edge): state IDLE, all delay stages and tags 0, active_rows_q=N, out_data_o=0, out_valid_o=0, out_last_o=0, busy_o=0, in_ready_o=1 after reset. Reset mid-frame discards all in-flight data, no out_last_o.
- Config: cfg_ld_i in IDLE latches active_rows_i; 0 clamps to 1, >N clamps to N. Ignored in STREAM/DRAIN.
- States: IDLE, STREAM, DRAIN.
- in_ready_o = 1 in IDLE and STREAM, 0 in DRAIN. accept = in_valid_i & in_ready_o.
- advance = accept | (state==DRAIN). Nothing shifts without advance; input bubbles hold all stages.
- Row r: delay line of r+1 registers; each stage carries data, valid tag, last tag. On advance, stage 0 loads the row-r input word, valid=accept, last=in_last_i&accept. In DRAIN, data=0, tags=0.
- Rows r >= active_rows_q: stage 0 loads 0 and tags 0; outputs stay 0/invalid.
- out_data_o[r] = last stage of row r. out_valid_o[r] = adv_q & last-stage valid tag, where adv_q = advance registered one cycle. No repeated valid during bubbles.
- Latency: a word accepted at edge T appears on row r after r further advances; row 0 one cycle after accept.
- Transitions: IDLE->STREAM on accept without in_last_i. IDLE or STREAM->DRAIN on accept with in_last_i when active_rows_q>1. Accept with in_last_i and active_rows_q==1 -> IDLE directly. DRAIN runs exactly active_rows_q-1 cycles via a down-counter, then IDLE.
- out_last_o = out_valid_o[active_rows_q-1] & last-stage last tag of that row; pulses one cycle, coincident with the final DRAIN advance output.
- busy_o = (state != IDLE).
- Arithmetic: none; words pass through bit-exact, sign preserved.

Decomposition:
- Shared package: W = I_WIDTH+F_WIDTH localparam, skew_state_t enum {IDLE, STREAM, DRAIN}, ROWS_WIDTH helper.
- Sub-module skew_row_delay (parameter DEPTH, W): enable-driven delay line carrying data, valid, and last tags; instantiated N times via generate with DEPTH=r+1.
- Top holds the FSM, drain counter, config register, adv_q, and output packing.

Test Plan:
1. N=3, active_rows=3, beats A0..A3 back-to-back (row r word = 16*k+r), last on A3 -> row0 valid cycles 1-4, row1 cycles 2-5, row2 cycles 3-6. in_ready_o low 2 cycles, out_last_o with A3 on row2.
2. Same frame with in_valid_i bubble after A1 -> outputs hold, out_valid_o=0 during bubble, sequence resumes intact, no duplicate valids.
3. active_rows=1, single beat 0x7F00 with in_last_i from IDLE -> row0 valid next cycle, out_last_o same cycle, straight to IDLE, in_ready_o never low.
4. active_rows=2 -> row2 out_data_o=0 and out_valid_o[2]=0 throughout; DRAIN lasts 1 cycle; out_last_o on row1.
5. cfg_ld_i with active_rows_i=1 during STREAM -> ignored, drain still 2 cycles. active_rows_i=0 in IDLE -> behaves as 1.
6. rst_n_i low during DRAIN -> next cycle all outputs 0, busy_o=0, in_ready_o=1, no out_last_o. A fresh frame then runs correctly.
